// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO built on a single-port
// synchronous RAM. Reads (prefetch into a one-entry output register) take
// priority over writes on the shared RAM port; a read issued at one edge
// returns its data for capture at the next edge.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // write side
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  // read side
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  // status
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  // RAM port
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              inflight;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  logic rd_issue;
  logic wr_fire;
  logic pop;

  // Port arbitration: prefetch a RAM word whenever the output register will be
  // free when the data returns; writes only use cycles the prefetch leaves idle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    rd_issue = 1'b0;
    wr_ready = 1'b0;
    if (ram_cnt != '0 && !inflight && (!out_valid || rd_ready))
      rd_issue = 1'b1;
    if (rst_n && !full && !rd_issue)
      wr_ready = 1'b1;
  end

  assign full     = (ram_cnt == DEPTH);
  assign wr_fire  = wr_valid && wr_ready;
  assign pop      = out_valid && rd_ready;

  assign ram_we   = wr_fire;
  assign ram_addr = rd_issue ? rptr : wptr;
  assign ram_din  = wr_data;

  assign rd_valid = out_valid;
  assign rd_data  = out_data;

  // count is built purely from registers, so it only moves at edges or reset.
  assign count = ram_cnt + (ADDR_W+1)'(inflight) + (ADDR_W+1)'(out_valid);
  assign empty = (count == '0);

  // Pointers and RAM occupancy; a read issue and a write never share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rd_issue) begin
        rptr    <= rptr + ADDR_W'(1);
        ram_cnt <= ram_cnt - (ADDR_W+1)'(1);
      end else if (wr_fire) begin
        wptr    <= wptr + ADDR_W'(1);
        ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  // In-flight read tracking and the output register; a return lands in the
  // register even when the consumer pops in the same cycle (replace).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      inflight <= rd_issue;
      if (inflight) begin
        out_data  <= ram_dout;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl with a behavioural
// single-port synchronous RAM attached to its RAM port.
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  int vectors;
  int miscompares;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Behavioural RAM: write at the edge with we=1, read data valid the cycle after.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int wexp;      // bench-side write pointer (accepted writes since reset)
  int accepted;
  int got_n;
  int sent;
  int we_seen;
  int max_cnt;
  int stale;
  int waited;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    wexp = 0;

    // ---------------- reset ----------------
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rel_wr_ready", 32'(wr_ready), 1);

    // ---------------- single word ----------------
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b0;
    #1;
    check("sw_wr_ready", 32'(wr_ready), 1);
    check("sw_ram_we", 32'(ram_we), 1);
    check("sw_ram_addr", 32'(ram_addr), 0);
    check("sw_ram_din", 32'(ram_din), 32'hA5);
    if (wr_ready) wexp++;
    @(negedge clk);                       // after E0
    wr_valid = 1'b0;
    #1;
    check("sw_rd_we", 32'(ram_we), 0);
    check("sw_rd_addr", 32'(ram_addr), 0);
    check("sw_rd_wr_ready", 32'(wr_ready), 0);
    check("sw_count_e0", 32'(count), 1);
    @(negedge clk); #1;                   // after E1
    check("sw_rd_valid_e1", 32'(rd_valid), 0);
    @(negedge clk); #1;                   // after E2
    check("sw_rd_valid_e2", 32'(rd_valid), 1);
    check("sw_rd_data", 32'(rd_data), 32'hA5);
    check("sw_count_e2", 32'(count), 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("sw_pop_empty", 32'(empty), 1);
    check("sw_pop_count", 32'(count), 0);

    // ---------------- fill ----------------
    accepted = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'(accepted); rd_ready = 1'b0;
      #1;
      if (wr_ready) begin
        check("fill_addr", 32'(ram_addr), 32'(wexp % 16));
        wexp++;
        accepted++;
      end
    end
    check("fill_accepted", 32'(accepted), 17);
    check("fill_full", 32'(full), 1);
    check("fill_wr_ready", 32'(wr_ready), 0);
    check("fill_count", 32'(count), 17);

    // ---------------- drain ----------------
    got_n = 0; we_seen = 0;
    for (int c = 0; c < 100 && got_n < 17; c++) begin
      @(negedge clk);
      wr_valid = 1'b0; rd_ready = 1'b1;
      #1;
      if (ram_we) we_seen++;
      if (rd_valid) begin
        check("drain_data", 32'(rd_data), 32'(got_n));
        got_n++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("drain_words", 32'(got_n), 17);
    check("drain_no_writes", 32'(we_seen), 0);
    check("drain_empty", 32'(empty), 1);

    // ---------------- streaming ----------------
    sent = 0; got_n = 0; max_cnt = 0;
    for (int c = 0; c < 400 && got_n < 40; c++) begin
      @(negedge clk);
      wr_valid = (sent < 40);
      wr_data  = 8'(8'h80 + sent);
      rd_ready = 1'b1;
      #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (wr_valid && wr_ready) begin
        check("stream_addr", 32'(ram_addr), 32'(wexp % 16));
        wexp++;
        sent++;
      end
      if (rd_valid) begin
        check("stream_data", 32'(rd_data), 32'(8'h80 + got_n));
        got_n++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    check("stream_sent", 32'(sent), 40);
    check("stream_recv", 32'(got_n), 40);
    check("stream_max_count_le17", 32'(max_cnt <= 17), 1);
    check("stream_empty", 32'(empty), 1);

    // ---------------- mid-operation reset ----------------
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 6; c++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'(8'h50 + accepted); rd_ready = 1'b0;
      #1;
      if (wr_ready) begin
        wexp++;
        accepted++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mr_count6", 32'(count), 6);
    check("mr_head", 32'(rd_data), 32'h50);
    rd_ready = 1'b1;                      // pop head and issue next read together
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("mr_count5", 32'(count), 5);
    check("mr_inflight_no_valid", 32'(rd_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_rst_rd_valid", 32'(rd_valid), 0);
    check("mr_rst_count", 32'(count), 0);
    check("mr_rst_empty", 32'(empty), 1);
    check("mr_rst_wr_ready", 32'(wr_ready), 0);
    wexp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (rd_valid || count != 0) stale++;
    end
    check("mr_no_stale", 32'(stale), 0);
    accepted = 0;
    for (int c = 0; c < 10 && accepted == 0; c++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'h3C;
      #1;
      if (wr_ready) begin
        check("mr_new_addr", 32'(ram_addr), 0);
        accepted++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    check("mr_new_accepted", 32'(accepted), 1);
    waited = 0;
    for (int c = 0; c < 10 && !rd_valid; c++) begin
      @(negedge clk); #1;
      waited++;
    end
    check("mr_new_valid", 32'(rd_valid), 1);
    check("mr_new_data", 32'(rd_data), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
